conv_window_sequencer: RTL and testbench

//  Control sequencer for the shared FP multiply-accumulate convolution datapath. On start it walks

---
 rtl/conv_window_sequencer.sv | 139 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every KxK window of an NxN input, issuing MAC ops and writing returned results.
// Optional CONV_SEQ_PERF_EN adds stall_cycles/issue_cycles performance counters.
module conv_window_sequencer #(
  parameter int MAX_FILTER = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  input_size,
  input  logic [7:0]  filter_size,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] in_addr,
  output logic [7:0]  flt_addr,
  output logic        op_first,
  output logic        op_last,
  input  logic        res_valid,
  output logic        out_we,
  output logic [15:0] out_addr,
  output logic [7:0]  output_size,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_cycles
`endif
);
  localparam logic [8:0] MAXF = 9'(MAX_FILTER);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] n_sz, k_sz, row, col, m, n;
  logic [15:0] win_base;
  logic [3:0] outstanding;
  logic run, fire, first_tap, last_tap, last_win, acc_start, cfg_bad;
  assign acc_start = state == IDLE && start;
  assign run = state == RUN;
  assign first_tap = m == 8'd0 && n == 8'd0;
  assign last_tap = m == k_sz - 8'd1 && n == k_sz - 8'd1;
  assign last_win = row == output_size - 8'd1 && col == output_size - 8'd1;
  // a new window may not start while the result pipeline is full
  assign op_valid = run && !(first_tap && outstanding == MAXO);
  assign fire = op_valid && op_ready;
  assign op_first = run && first_tap;
  assign op_last = run && last_tap;
  assign out_we = res_valid && (run || state == DRAIN) && outstanding != 4'd0;
  assign busy = state == CHECK || run || state == DRAIN;
  assign done = state == DONE;
  assign cfg_bad = k_sz == 8'd0 || n_sz == 8'd0 || k_sz > n_sz || {1'b0, k_sz} > MAXF;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CHECK : IDLE;
      CHECK:   state_nx = cfg_bad ? DONE : RUN;
      RUN:     state_nx = fire && last_tap && last_win ? DRAIN : RUN;
      DRAIN:   state_nx = outstanding == {3'd0, out_we} ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      n_sz <= 8'd0;
      k_sz <= 8'd0;
      row <= 8'd0;
      col <= 8'd0;
      m <= 8'd0;
      n <= 8'd0;
      win_base <= 16'd0;
      in_addr <= 16'd0;
      flt_addr <= 8'd0;
      out_addr <= 16'd0;
      output_size <= 8'd0;
      outstanding <= 4'd0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc_start) begin
        n_sz <= input_size;
        k_sz <= filter_size;
        err <= 1'b0;
        out_addr <= 16'd0;
      end
      if (state == CHECK) begin
        err <= cfg_bad;
        output_size <= cfg_bad ? 8'd0 : n_sz - k_sz + 8'd1;
        row <= 8'd0;
        col <= 8'd0;
        m <= 8'd0;
        n <= 8'd0;
        win_base <= 16'd0;
        in_addr <= 16'd0;
        flt_addr <= 8'd0;
      end
      if (fire) begin
        flt_addr <= last_tap ? 8'd0 : flt_addr + 8'd1;
        if (n != k_sz - 8'd1) begin
          n <= n + 8'd1;
          in_addr <= in_addr + 16'd1;
        end else if (m != k_sz - 8'd1) begin
          n <= 8'd0;
          m <= m + 8'd1;
          in_addr <= in_addr + {8'd0, n_sz} - {8'd0, k_sz} + 16'd1;
        end else begin
          n <= 8'd0;
          m <= 8'd0;
          if (col != output_size - 8'd1) begin
            col <= col + 8'd1;
            win_base <= win_base + 16'd1;
            in_addr <= win_base + 16'd1;
          end else begin
            // base of last window in a row plus K lands on the next row start
            col <= 8'd0;
            row <= row + 8'd1;
            win_base <= win_base + {8'd0, k_sz};
            in_addr <= win_base + {8'd0, k_sz};
          end
        end
      end
      outstanding <= outstanding + {3'd0, fire && last_tap} - {3'd0, out_we};
      if (out_we) out_addr <= out_addr + 16'd1;
    end
`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cycles <= 32'd0;
      issue_cycles <= 32'd0;
    end else if (acc_start) begin
      stall_cycles <= 32'd0;
      issue_cycles <= 32'd0;
    end else begin
      if (run && !fire) stall_cycles <= stall_cycles + 32'd1;
      if (fire) issue_cycles <= issue_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: randomized scoreboard bench comparing ops and result writes to a window-walk model.
module tb_conv_window_sequencer;
  logic clk = 0, rst = 1, start = 0, op_ready = 0, res_valid = 0;
  logic [7:0] input_size = 0, filter_size = 0;
  logic op_valid, op_first, op_last, out_we, busy, done, err;
  logic [15:0] in_addr, out_addr;
  logic [7:0] flt_addr, output_size;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_cycles, issue_cycles;
`endif
  conv_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .input_size(input_size), .filter_size(filter_size),
    .op_valid(op_valid), .op_ready(op_ready), .in_addr(in_addr), .flt_addr(flt_addr),
    .op_first(op_first), .op_last(op_last), .res_valid(res_valid), .out_we(out_we),
    .out_addr(out_addr), .output_size(output_size), .busy(busy), .done(done), .err(err)
`ifdef CONV_SEQ_PERF_EN
    , .stall_cycles(stall_cycles), .issue_cycles(issue_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int ia; int fa; bit f; bit l;} op_t;
  op_t exp_ops[$];
  int exp_out[$];
  int res_due[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int ready_mode = 0, res_lat = 3;
  bit res_hold = 0, stray_res = 0;
  int done_cnt = 0, done_cyc = 0, last_we_cyc = 0, first_op_cyc = -1, fires = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    op_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
    if (!rst && !res_hold && res_due.size() > 0 && res_due[0] <= cyc) begin
      res_valid = 1;
      void'(res_due.pop_front());
    end else res_valid = stray_res;
  end
  always @(negedge clk) begin
    int due;
    op_t e;
    if (!rst) begin
      if (op_valid && op_ready) begin
        fires++;
        if (first_op_cyc < 0) first_op_cyc = cyc;
        if (exp_ops.size() == 0) chk("unexpected_op", 1, 0);
        else begin
          e = exp_ops.pop_front();
          chk("in_addr", in_addr, e.ia);
          chk("flt_addr", flt_addr, e.fa);
          chk("first_last", {op_first, op_last}, {e.f, e.l});
        end
        if (op_last) begin
          due = res_lat > 0 ? cyc + res_lat : cyc + $urandom_range(1, 5);
          if (res_due.size() > 0 && due < res_due[$]) due = res_due[$];
          res_due.push_back(due);
        end
      end
      if (out_we) begin
        last_we_cyc = cyc;
        if (exp_out.size() == 0) chk("unexpected_we", 1, 0);
        else chk("out_addr", out_addr, exp_out.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  function automatic bit is_bad(input int n, input int k);
    return k == 0 || n == 0 || k > n || k > 16;
  endfunction
  task automatic begin_run(input int n, input int k, input int mode, input int lat,
                           output int s, output int f0, output int d0);
    int mm = n - k + 1;
    if (!is_bad(n, k))
      for (int r = 0; r < mm; r++)
        for (int c = 0; c < mm; c++) begin
          for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
              exp_ops.push_back('{(r + i) * n + c + j, i * k + j, i == 0 && j == 0, i == k - 1 && j == k - 1});
          exp_out.push_back(r * mm + c);
        end
    ready_mode = mode;
    res_lat = lat;
    f0 = fires;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    input_size = 8'(n);
    filter_size = 8'(k);
    start = 1;
    s = cyc;
    first_op_cyc = -1;
    @(posedge clk);
    #2;
    start = 0;
    input_size = 8'($urandom);
    filter_size = 8'($urandom);
  endtask
  task automatic end_run(input int n, input int k, input int mode, input int s, input int f0, input int d0);
    bit bad = is_bad(n, k);
    int ops = bad ? 0 : (n - k + 1) * (n - k + 1) * k * k;
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err", err, bad);
    chk("busy_after", busy, 0);
    chk("op_count", fires - f0, ops);
    chk("ops_left", exp_ops.size(), 0);
    chk("outs_left", exp_out.size(), 0);
    if (bad) chk("err_done_lat", done_cyc - s, 2);
    else begin
      chk("output_size", output_size, n - k + 1);
      chk("done_after_res", done_cyc - last_we_cyc, 1);
      if (mode == 0) chk("start_lat", first_op_cyc - s, 2);
    end
`ifdef CONV_SEQ_PERF_EN
    chk("issue_cycles", issue_cycles, ops);
`endif
  endtask
  task automatic run_cfg(input int n, input int k, input int mode, input int lat, input bit inject);
    int s, f0, d0;
    begin_run(n, k, mode, lat, s, f0, d0);
    if (inject) begin
      repeat (10) @(posedge clk);
      #2;
      start = 1;
      input_size = 8'd9;
      filter_size = 8'd2;
      @(posedge clk);
      #2;
      start = 0;
    end
    end_run(n, k, mode, s, f0, d0);
  endtask
  initial begin
    int s, f0, d0, n, k;
    repeat (3) @(negedge clk);
    chk("reset_state", {op_valid, op_first, op_last, out_we, busy, done, err, in_addr, flt_addr, out_addr, output_size}, 0);
    @(posedge clk);
    #2;
    rst = 0;
    run_cfg(3, 2, 0, 3, 0);
    run_cfg(3, 4, 0, 3, 0);
    run_cfg(3, 0, 0, 3, 0);
    run_cfg(20, 17, 0, 3, 0);
    run_cfg(4, 1, 0, 3, 0);
    run_cfg(5, 3, 1, 0, 1);
    // throttling: results withheld until the outstanding limit is reached
    res_hold = 1;
    begin_run(5, 2, 0, 2, s, f0, d0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("throttle_ops", fires - f0, 16);
    chk("throttle_valid", op_valid, 0);
    chk("throttle_first", {busy, op_first}, 2'b11);
    res_hold = 0;
    @(negedge clk);
    chk("release_we", out_we, 1);
    chk("release_valid", op_valid, 0);
    @(negedge clk);
    chk("resume_valid", op_valid, 1);
    end_run(5, 2, 0, s, f0, d0);
    stray_res = 1;
    @(negedge clk);
    chk("stray_we", out_we, 0);
    stray_res = 0;
    begin_run(5, 3, 2, 0, s, f0, d0);
    repeat (30) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("rst_outputs", {op_valid, op_first, op_last, out_we, busy, done, err, in_addr, flt_addr, out_addr, output_size}, 0);
    exp_ops.delete();
    exp_out.delete();
    res_due.delete();
    @(posedge clk);
    #2;
    rst = 0;
    run_cfg(4, 1, 0, 3, 0);
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 7);
      k = $urandom_range(0, n + 1);
      run_cfg(n, k, 2, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
